ascon_job_ctrl: RTL and testbench

ASCON_JOB_CTRL -- requirements
Module: ascon_job_ctrl

---
 rtl/ascon_pkg.sv | 22 ++
 rtl/ascon_job_ctrl_if.sv | 28 ++
 rtl/ascon_timeout_cnt.sv | 39 +++
 rtl/ascon_job_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ascon_job_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types and constants for the ascon job controller
package ascon_pkg;

    typedef logic [63:0]  word_t;
    typedef logic [127:0] wide_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ENC = 2'b00;
    localparam logic [1:0] MODE_DEC = 2'b01;

    // Only plain encrypt/decrypt are launchable; 1x is rejected without touching the core.
    function automatic logic mode_is_legal(input logic [1:0] mode);
        return (mode == MODE_ENC) || (mode == MODE_DEC);
    endfunction

endpackage

// File: rtl/ascon_job_ctrl_if.sv
// rtl/ascon_job_ctrl_if.sv - controller to ascon_core launch/completion interface
interface ascon_job_ctrl_if;
    import ascon_pkg::*;

    logic  core_start;
    logic  core_mode;
    wide_t core_key;
    wide_t core_nonce;
    word_t core_ad     [0:1];
    word_t core_pt     [0:1];

    logic  core_done;
    logic  core_error;
    word_t core_ct     [0:1];
    word_t core_tag    [0:1];
    word_t core_pt_out [0:1];

    modport master (
        output core_start, core_mode, core_key, core_nonce, core_ad, core_pt,
        input  core_done, core_error, core_ct, core_tag, core_pt_out
    );

    modport slave (
        input  core_start, core_mode, core_key, core_nonce, core_ad, core_pt,
        output core_done, core_error, core_ct, core_tag, core_pt_out
    );

endinterface

// File: rtl/ascon_timeout_cnt.sv
// rtl/ascon_timeout_cnt.sv - saturating wait-cycle counter with terminal flag
module ascon_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count up while enabled, parking on the last value so the counter can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = (cnt_q == CNT_LAST);

endmodule

// File: rtl/ascon_job_ctrl.sv
// rtl/ascon_job_ctrl.sv - CSR-driven job sequencer around the ascon core
module ascon_job_ctrl
    import ascon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            encrypt_decrypt,
    input  wide_t                 key,
    input  wide_t                 nonce,
    input  word_t                 associated_data [0:1],
    input  word_t                 plaintext_in    [0:1],
    ascon_job_ctrl_if.master      core,
    output word_t                 ciphertext_out  [0:1],
    output word_t                 tag             [0:1],
    output word_t                 plaintext_out   [0:1],
    output logic                  done,
    output logic                  error,
    output logic                  busy
);

    state_t state_q, state_d;
    logic   start_q;
    logic   core_start_q, core_start_d;
    logic   core_mode_q, core_mode_d;
    wide_t  key_q, key_d;
    wide_t  nonce_q, nonce_d;
    word_t  ad_q  [0:1];
    word_t  ad_d  [0:1];
    word_t  pt_q  [0:1];
    word_t  pt_d  [0:1];
    word_t  ct_q  [0:1];
    word_t  ct_d  [0:1];
    word_t  tag_q [0:1];
    word_t  tag_d [0:1];
    word_t  pto_q [0:1];
    word_t  pto_d [0:1];
    logic   done_q, done_d;
    logic   error_q, error_d;
    logic   busy_q, busy_d;

    logic   start_edge;
    logic   mode_ok;
    logic   tmo_terminal;

    // A held-high start only produces one request because start_q follows it every cycle.
    assign start_edge = start & ~start_q;
    assign mode_ok    = mode_is_legal(encrypt_decrypt);

    ascon_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == LAUNCH),
        .enable   (state_q == WAIT),
        .terminal (tmo_terminal)
    );

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            core_start_q <= 1'b0;
            core_mode_q  <= 1'b0;
            key_q        <= '0;
            nonce_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                ad_q[i]  <= '0;
                pt_q[i]  <= '0;
                ct_q[i]  <= '0;
                tag_q[i] <= '0;
                pto_q[i] <= '0;
            end
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            core_start_q <= core_start_d;
            core_mode_q  <= core_mode_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            for (int i = 0; i < 2; i++) begin
                ad_q[i]  <= ad_d[i];
                pt_q[i]  <= pt_d[i];
                ct_q[i]  <= ct_d[i];
                tag_q[i] <= tag_d[i];
                pto_q[i] <= pto_d[i];
            end
            done_q       <= done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: requests only count in IDLE/DONE; completion beats timeout in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d = mode_ok ? LAUNCH : DONE;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core.core_done || tmo_terminal) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath: snapshot on accept, capture on completion, flag errors.
    always_comb begin
        core_start_d = 1'b0;
        core_mode_d  = core_mode_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        for (int i = 0; i < 2; i++) begin
            ad_d[i]  = ad_q[i];
            pt_d[i]  = pt_q[i];
            ct_d[i]  = ct_q[i];
            tag_d[i] = tag_q[i];
            pto_d[i] = pto_q[i];
        end
        done_d       = done_q;
        error_d      = error_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    if (mode_ok) begin
                        core_start_d = 1'b1;
                        core_mode_d  = encrypt_decrypt[0];
                        key_d        = key;
                        nonce_d      = nonce;
                        for (int i = 0; i < 2; i++) begin
                            ad_d[i] = associated_data[i];
                            pt_d[i] = plaintext_in[i];
                        end
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                        busy_d       = 1'b1;
                    end else begin
                        // Illegal mode: report immediately, leave snapshot and results alone.
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (core.core_done) begin
                    for (int i = 0; i < 2; i++) begin
                        ct_d[i]  = core.core_ct[i];
                        tag_d[i] = core.core_tag[i];
                        pto_d[i] = core.core_pt_out[i];
                    end
                    done_d  = 1'b1;
                    error_d = core.core_error;
                    busy_d  = 1'b0;
                end else if (tmo_terminal) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign core.core_start = core_start_q;
    assign core.core_mode  = core_mode_q;
    assign core.core_key   = key_q;
    assign core.core_nonce = nonce_q;
    assign core.core_ad[0] = ad_q[0];
    assign core.core_ad[1] = ad_q[1];
    assign core.core_pt[0] = pt_q[0];
    assign core.core_pt[1] = pt_q[1];

    assign ciphertext_out[0] = ct_q[0];
    assign ciphertext_out[1] = ct_q[1];
    assign tag[0]            = tag_q[0];
    assign tag[1]            = tag_q[1];
    assign plaintext_out[0]  = pto_q[0];
    assign plaintext_out[1]  = pto_q[1];

    assign done  = done_q;
    assign error = error_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_ascon_job_ctrl.sv
// tb/tb_ascon_job_ctrl.sv - self-checking bench for ascon_job_ctrl
module tb_ascon_job_ctrl;

    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   encrypt_decrypt = 2'b00;
    logic [127:0] key = '0;
    logic [127:0] nonce = '0;
    logic [63:0]  associated_data [0:1];
    logic [63:0]  plaintext_in    [0:1];
    logic [63:0]  ciphertext_out  [0:1];
    logic [63:0]  tag             [0:1];
    logic [63:0]  plaintext_out   [0:1];
    logic         done, error, busy;

    ascon_job_ctrl_if cif();

    ascon_job_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .encrypt_decrypt (encrypt_decrypt),
        .key             (key),
        .nonce           (nonce),
        .associated_data (associated_data),
        .plaintext_in    (plaintext_in),
        .core            (cif),
        .ciphertext_out  (ciphertext_out),
        .tag             (tag),
        .plaintext_out   (plaintext_out),
        .done            (done),
        .error           (error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected held results and operand snapshot.
    logic [63:0]  m_ct [0:1], m_tag [0:1], m_pto [0:1];
    logic [127:0] m_key, m_nonce;
    logic [63:0]  m_ad [0:1], m_pt [0:1];
    // Values the core model returns for the current job.
    logic [63:0]  cm_ct [0:1], cm_tag [0:1], cm_pto [0:1];

    typedef struct {
        logic [1:0] mode;
        int         dly;      // core_done this many cycles after core_start; 0 = never
        logic       cerr;
        int         hold;     // keep start high until this cycle of the job
        bit         extra;    // second start edge while waiting
        int         e_launch;
        int         e_lat;    // cycles from start edge drive to done seen
        logic       e_err;
        bit         e_cap;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randomize_operands();
        key   = rnd128();
        nonce = rnd128();
        for (int i = 0; i < 2; i++) begin
            associated_data[i] = {$urandom, $urandom};
            plaintext_in[i]    = {$urandom, $urandom};
            cm_ct[i]           = {$urandom, $urandom};
            cm_tag[i]          = {$urandom, $urandom};
            cm_pto[i]          = {$urandom, $urandom};
        end
    endtask

    task automatic check_results(input string tagname);
        check({tagname, "_ct0"},  ciphertext_out[0], m_ct[0]);
        check({tagname, "_ct1"},  ciphertext_out[1], m_ct[1]);
        check({tagname, "_tag0"}, tag[0],            m_tag[0]);
        check({tagname, "_tag1"}, tag[1],            m_tag[1]);
        check({tagname, "_pto0"}, plaintext_out[0],  m_pto[0]);
        check({tagname, "_pto1"}, plaintext_out[1],  m_pto[1]);
    endtask

    task automatic run_job(input vec_t v);
        int c, launches, lat;
        logic err_at_done, busy_at_done;
        c = -1; launches = 0; lat = -1;
        err_at_done = 1'b0; busy_at_done = 1'b1;
        encrypt_decrypt = v.mode;
        start = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (cif.core_start === 1'b1) begin
                launches++;
                if (c < 0) begin
                    c = t;
                    check("launch_lat", 128'(t), 128'(1));
                    check("busy_launch", busy, 1);
                    check("done_clr", done, 0);
                    check("err_clr", error, 0);
                    check("core_mode", cif.core_mode, v.mode[0]);
                    check("core_key", cif.core_key, key);
                    check("core_nonce", cif.core_nonce, nonce);
                    check("core_ad0", cif.core_ad[0], associated_data[0]);
                    check("core_ad1", cif.core_ad[1], associated_data[1]);
                    check("core_pt0", cif.core_pt[0], plaintext_in[0]);
                    check("core_pt1", cif.core_pt[1], plaintext_in[1]);
                    m_key = key; m_nonce = nonce;
                    m_ad[0] = associated_data[0]; m_ad[1] = associated_data[1];
                    m_pt[0] = plaintext_in[0];    m_pt[1] = plaintext_in[1];
                end
            end
            if (done === 1'b1 && lat < 0) begin
                lat = t;
                err_at_done = error;
                busy_at_done = busy;
            end
            if (c > 0 && v.dly > 0 && t == c + v.dly) begin
                cif.core_done  = 1'b1;
                cif.core_error = v.cerr;
                for (int i = 0; i < 2; i++) begin
                    cif.core_ct[i]     = cm_ct[i];
                    cif.core_tag[i]    = cm_tag[i];
                    cif.core_pt_out[i] = cm_pto[i];
                end
            end else begin
                cif.core_done  = 1'b0;
                cif.core_error = 1'b0;
            end
            if (v.extra && t == 3) start = 1'b0;
            if (v.extra && t == 5) start = 1'b1;
            if (lat > 0 && t >= lat + 3 && t >= v.hold) break;
        end
        cif.core_done = 1'b0;
        check("launches", 128'(launches), 128'(v.e_launch));
        check("done_lat", 128'(lat), 128'(v.e_lat));
        check("err_at_done", err_at_done, v.e_err);
        check("busy_at_done", busy_at_done, 0);
        check("done_hold", done, 1);
        check("err_hold", error, v.e_err);
        if (v.e_cap) begin
            for (int i = 0; i < 2; i++) begin
                m_ct[i] = cm_ct[i]; m_tag[i] = cm_tag[i]; m_pto[i] = cm_pto[i];
            end
        end
        check_results("res");
        check("snap_key", cif.core_key, m_key);
        check("snap_pt1", cif.core_pt[1], m_pt[1]);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Job-level expectation from the latency and priority rules.
    function automatic vec_t predict(input logic [1:0] mode, input int dly, input logic cerr, input bit extra);
        vec_t v;
        v.mode = mode; v.dly = dly; v.cerr = cerr; v.hold = 0; v.extra = extra;
        if (mode[1]) begin
            v.e_launch = 0; v.e_lat = 1; v.e_err = 1'b1; v.e_cap = 1'b0;
        end else if (dly >= 1 && dly <= T) begin
            v.e_launch = 1; v.e_lat = dly + 2; v.e_err = cerr; v.e_cap = 1'b1;
        end else begin
            v.e_launch = 1; v.e_lat = T + 2; v.e_err = 1'b1; v.e_cap = 1'b0;
        end
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            associated_data[i] = '0; plaintext_in[i] = '0;
            m_ct[i] = '0; m_tag[i] = '0; m_pto[i] = '0; m_ad[i] = '0; m_pt[i] = '0;
            cif.core_ct[i] = '0; cif.core_tag[i] = '0; cif.core_pt_out[i] = '0;
        end
        m_key = '0; m_nonce = '0;
        cif.core_done = 1'b0; cif.core_error = 1'b0;

        //           mode   dly cerr hold ex  L  lat err cap
        vecs[0]  = '{2'b10, 10, 0,   0,   0,  0, 1,  1,  0};
        vecs[1]  = '{2'b00, 10, 0,   0,   0,  1, 12, 0,  1};
        vecs[2]  = '{2'b00, 0,  0,   0,   0,  1, 18, 1,  0};
        vecs[3]  = '{2'b01, 3,  1,   0,   0,  1, 5,  1,  1};
        vecs[4]  = '{2'b00, 16, 1,   0,   0,  1, 18, 1,  1};
        vecs[5]  = '{2'b01, 16, 0,   0,   0,  1, 18, 0,  1};
        vecs[6]  = '{2'b00, 17, 0,   0,   0,  1, 18, 1,  0};
        vecs[7]  = '{2'b00, 10, 0,   50,  0,  1, 12, 0,  1};
        vecs[8]  = '{2'b01, 8,  0,   0,   1,  1, 10, 0,  1};
        vecs[9]  = '{2'b11, 5,  0,   0,   0,  0, 1,  1,  0};
        vecs[10] = '{2'b00, 1,  0,   0,   0,  1, 3,  0,  1};
        vecs[11] = '{2'b00, 15, 0,   0,   0,  1, 17, 0,  1};

        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_core_start", cif.core_start, 0);
        check("rst_key", cif.core_key, 0);
        check_results("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            randomize_operands();
            if (k == 1) begin
                key = 128'h000102030405060708090A0B0C0D0E0F;
                cm_ct[0]  = 64'hAAAA_AAAA_AAAA_AAAA;
                cm_tag[0] = 64'h1234_5678_9ABC_DEF0;
            end
            run_job(vecs[k]);
        end

        // Reset in the middle of WAIT, then a stray core_done after release.
        begin
            int seen;
            seen = 0;
            randomize_operands();
            encrypt_decrypt = 2'b00;
            start = 1'b1;
            for (int t = 0; t < 10 && seen == 0; t++) begin
                @(negedge clk);
                if (cif.core_start === 1'b1) seen = 1;
            end
            check("rstseq_launch", 128'(seen), 128'(1));
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_ct[i] = '0; m_tag[i] = '0; m_pto[i] = '0; m_pt[i] = '0;
            end
            m_key = '0;
            check("rstseq_busy", busy, 0);
            check("rstseq_key", cif.core_key, 0);
            check_results("rstseq");
            for (int t = 1; t <= 6; t++) begin
                @(negedge clk);
                if (t == 2) begin
                    cif.core_done = 1'b1; cif.core_error = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        cif.core_ct[i] = cm_ct[i]; cif.core_tag[i] = cm_tag[i];
                    end
                end else begin
                    cif.core_done = 1'b0; cif.core_error = 1'b0;
                end
                check("rstseq_done", done, 0);
                check("rstseq_err", error, 0);
                check("rstseq_cs", cif.core_start, 0);
            end
            check_results("rstseq_after");
        end

        for (int k = 0; k < 30; k++) begin
            int r, d;
            logic [1:0] m;
            bit ex;
            r = $urandom_range(0, 9);
            m = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            d = $urandom_range(0, 20);
            ex = (!m[1]) && (d >= 6) && ($urandom_range(0, 2) == 0);
            randomize_operands();
            run_job(predict(m, d, 1'($urandom_range(0, 1)), ex));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
